// File: rtl/filtered_bit_synchronizer.sv
// rtl/filtered_bit_synchronizer.sv - multi-lane bit synchronizer with glitch filter and edge pulses
// Optional sticky change flags (i_clear/o_changed) are built when FILTERED_SYNC_STICKY_EN is defined.
module filtered_bit_synchronizer #(
  parameter int CHANNELS      = 1,
  parameter int STAGES        = 2,
  parameter int FILTER_CYCLES = 0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [CHANNELS-1:0] i_bit_in,
`ifdef FILTERED_SYNC_STICKY_EN
  input  logic [CHANNELS-1:0] i_clear,
  output logic [CHANNELS-1:0] o_changed,
`endif
  output logic [CHANNELS-1:0] o_sync,
  output logic [CHANNELS-1:0] o_rise,
  output logic [CHANNELS-1:0] o_fall
);

  localparam int CW = (FILTER_CYCLES > 0) ? $clog2(FILTER_CYCLES + 1) : 1;

  if (CHANNELS < 1) begin : g_bad_channels
    $error("filtered_bit_synchronizer: CHANNELS must be >= 1");
  end
  if (STAGES < 2) begin : g_bad_stages
    $error("filtered_bit_synchronizer: STAGES must be >= 2");
  end
  if (FILTER_CYCLES < 0) begin : g_bad_filter
    $error("filtered_bit_synchronizer: FILTER_CYCLES must be >= 0");
  end

  logic [CHANNELS-1:0] w_s;
  logic [CHANNELS-1:0] w_level;
  logic [CHANNELS-1:0] r_d;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO" *)
    logic [STAGES-1:0] r_chain;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_chain <= '0;
      end else begin
        r_chain <= {r_chain[STAGES-2:0], i_bit_in[g]};
      end
    end

    assign w_s[g] = r_chain[STAGES-1];

    if (FILTER_CYCLES == 0) begin : g_nofilt
      assign w_level[g] = w_s[g];
    end else begin : g_filt
      logic [CW-1:0] r_cnt;
      logic          r_f;

      // Any sample matching the held level restarts the count, so glitches never accumulate.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_cnt <= '0;
          r_f   <= 1'b0;
        end else if (w_s[g] == r_f) begin
          r_cnt <= '0;
        end else if (r_cnt == CW'(FILTER_CYCLES - 1)) begin
          r_f   <= w_s[g];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end

      assign w_level[g] = r_f;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_d <= '0;
    end else begin
      r_d <= w_level;
    end
  end

  assign o_sync = w_level;
  assign o_rise = w_level & ~r_d;
  assign o_fall = ~w_level & r_d;

`ifdef FILTERED_SYNC_STICKY_EN
  logic [CHANNELS-1:0] r_changed;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_changed <= '0;
    end else begin
      r_changed <= (r_changed & ~i_clear) | o_rise | o_fall;
    end
  end

  assign o_changed = r_changed;
`endif

endmodule

// File: tb/tb_filtered_bit_synchronizer.sv
// tb/tb_filtered_bit_synchronizer.sv - scoreboard bench for filtered_bit_synchronizer
// Exercises FILTERED_SYNC_STICKY_EN behaviour only when that macro is defined.
module tb_filtered_bit_synchronizer;

  typedef struct {
    int         c;
    logic [3:0] s;
    logic [3:0] r;
    logic [3:0] f;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] a_in;
  logic [3:0] a_sync, a_rise, a_fall;
  logic [0:0] b_in;
  logic [0:0] b_sync, b_rise, b_fall;
`ifdef FILTERED_SYNC_STICKY_EN
  logic [3:0] a_clear;
  logic [3:0] a_changed;
  logic [0:0] b_changed;
`endif

  int  cyc = 0;
  int  n_tests = 0;
  int  n_fail = 0;
  ev_t qa[$];
  ev_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  filtered_bit_synchronizer #(.CHANNELS(4), .STAGES(2), .FILTER_CYCLES(3)) u_a (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_bit_in (a_in),
`ifdef FILTERED_SYNC_STICKY_EN
    .i_clear  (a_clear),
    .o_changed(a_changed),
`endif
    .o_sync   (a_sync),
    .o_rise   (a_rise),
    .o_fall   (a_fall)
  );

  filtered_bit_synchronizer #(.CHANNELS(1), .STAGES(3), .FILTER_CYCLES(0)) u_b (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_bit_in (b_in),
`ifdef FILTERED_SYNC_STICKY_EN
    .i_clear  (1'b0),
    .o_changed(b_changed),
`endif
    .o_sync   (b_sync),
    .o_rise   (b_rise),
    .o_fall   (b_fall)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_a(input int c, input logic [3:0] s, input logic [3:0] r, input logic [3:0] f);
    ev_t e;
    e.c = c; e.s = s; e.r = r; e.f = f;
    qa.push_back(e);
  endtask

  task automatic push_b(input int c, input logic s, input logic r, input logic f);
    ev_t e;
    e.c = c; e.s = {3'b0, s}; e.r = {3'b0, r}; e.f = {3'b0, f};
    qb.push_back(e);
  endtask

  // Every edge pulse must match the next expected event exactly.
  always @(negedge clk) begin
    ev_t e;
    if ((a_rise | a_fall) != 4'h0) begin
      n_tests++;
      if (qa.size() == 0) begin
        n_fail++;
        $display("FAIL a_spurious: cyc %0d sync %h rise %h fall %h, expected no pulse", cyc, a_sync, a_rise, a_fall);
      end else begin
        e = qa.pop_front();
        if (e.c != cyc || e.s !== a_sync || e.r !== a_rise || e.f !== a_fall) begin
          n_fail++;
          $display("FAIL a_event: got cyc %0d sync %h rise %h fall %h, expected cyc %0d sync %h rise %h fall %h",
                   cyc, a_sync, a_rise, a_fall, e.c, e.s, e.r, e.f);
        end
      end
    end
  end

  always @(negedge clk) begin
    ev_t e;
    if ((b_rise | b_fall) != 1'b0) begin
      n_tests++;
      if (qb.size() == 0) begin
        n_fail++;
        $display("FAIL b_spurious: cyc %0d sync %b rise %b fall %b, expected no pulse", cyc, b_sync, b_rise, b_fall);
      end else begin
        e = qb.pop_front();
        if (e.c != cyc || e.s[0] !== b_sync[0] || e.r[0] !== b_rise[0] || e.f[0] !== b_fall[0]) begin
          n_fail++;
          $display("FAIL b_event: got cyc %0d sync %b rise %b fall %b, expected cyc %0d sync %b rise %b fall %b",
                   cyc, b_sync, b_rise, b_fall, e.c, e.s[0], e.r[0], e.f[0]);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    a_in  = 4'hF;
    b_in  = 1'b0;
`ifdef FILTERED_SYNC_STICKY_EN
    a_clear = 4'h0;
`endif
    tick(3);
    check("reset_sync", {28'h0, a_sync}, 32'h0);
    check("reset_pulses", {24'h0, a_rise, a_fall}, 32'h0);
    check("reset_b", {29'h0, b_sync, b_rise, b_fall}, 32'h0);

    // Release with all lanes high: one Rise on all lanes at edge 5.
    rst_n = 1'b1;
    push_a(cyc + 5, 4'hF, 4'hF, 4'h0);
    tick(4);
    check("pre_latency_sync", {28'h0, a_sync}, 32'h0);
    tick(4);
    check("post_release_sync", {28'h0, a_sync}, 32'hF);

    a_in = 4'h0;
    push_a(cyc + 5, 4'h0, 4'h0, 4'hF);
    tick(8);

    // Repeated 2-cycle glitches on lane 0 must never pass.
    for (int k = 0; k < 10; k++) begin
      a_in[0] = 1'b1;
      tick(2);
      a_in[0] = 1'b0;
      tick(2);
    end
    tick(6);
    check("glitch_sync", {28'h0, a_sync}, 32'h0);

    a_in[0] = 1'b1;
    push_a(cyc + 5, 4'h1, 4'h1, 4'h0);
    tick(8);
    check("lane0_high", {28'h0, a_sync}, 32'h1);
    a_in[0] = 1'b0;
    push_a(cyc + 5, 4'h0, 4'h0, 4'h1);
    tick(8);

    // Asynchronous reset while lane 1 counter is at 2.
    a_in[3] = 1'b1;
    push_a(cyc + 5, 4'h8, 4'h8, 4'h0);
    tick(8);
    a_in[1] = 1'b1;
    tick(4);
    check("lane1_not_yet", {28'h0, a_sync}, 32'h8);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_sync", {28'h0, a_sync}, 32'h0);
    check("async_reset_pulses", {24'h0, a_rise, a_fall}, 32'h0);
    tick(2);
    rst_n = 1'b1;
    push_a(cyc + 5, 4'hA, 4'hA, 4'h0);
    tick(4);
    check("rerelease_latency", {28'h0, a_sync}, 32'h0);
    tick(4);
    a_in = 4'h0;
    push_a(cyc + 5, 4'h0, 4'h0, 4'hA);
    tick(8);

    // Unfiltered 3-stage lane: pulse and level.
    b_in = 1'b1;
    push_b(cyc + 3, 1'b1, 1'b1, 1'b0);
    push_b(cyc + 4, 1'b0, 1'b0, 1'b1);
    tick(1);
    b_in = 1'b0;
    tick(8);
    b_in = 1'b1;
    push_b(cyc + 3, 1'b1, 1'b1, 1'b0);
    tick(2);
    check("b_latency", {31'h0, b_sync}, 32'h0);
    tick(4);
    check("b_level", {31'h0, b_sync}, 32'h1);
    b_in = 1'b0;
    push_b(cyc + 3, 1'b0, 1'b0, 1'b1);
    tick(6);

`ifdef FILTERED_SYNC_STICKY_EN
    a_clear = 4'hF;
    tick(1);
    a_clear = 4'h0;
    check("changed_cleared", {28'h0, a_changed}, 32'h0);
    a_in[2] = 1'b1;
    push_a(cyc + 5, 4'h4, 4'h4, 4'h0);
    tick(5);
    a_clear[2] = 1'b1;
    tick(1);
    check("changed_set_wins", {31'h0, a_changed[2]}, 32'h1);
    tick(1);
    check("changed_clear", {31'h0, a_changed[2]}, 32'h0);
    a_clear = 4'h0;
    a_in = 4'h0;
    push_a(cyc + 5, 4'h0, 4'h0, 4'h4);
    tick(8);
`endif

    check("qa_drained", qa.size(), 32'h0);
    check("qb_drained", qb.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
